// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared types and width helpers for the adder self-test sequencer
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } state_t;

    function automatic int idx_width(input int w);
        return 2 * w;
    endfunction

    function automatic int num_vectors(input int w);
        return 1 << (2 * w);
    endfunction

    // One extra bit so that a run where every vector fails still fits.
    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

    localparam int BIST_WIDTH = 4;
    localparam int BIST_IDX_W = idx_width(BIST_WIDTH);
    localparam int BIST_N     = num_vectors(BIST_WIDTH);
    localparam int BIST_CNT_W = cnt_width(BIST_WIDTH);

endpackage

// File: rtl/adder_bist_ref.sv
// rtl/adder_bist_ref.sv - combinational golden model of a WIDTH-bit adder
module adder_bist_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign sum      = sum_ext[WIDTH-1:0];
    assign carry    = sum_ext[WIDTH];
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - exhaustive self-test sequencer for a WIDTH-bit adder
import adder_bist_pkg::*;

module adder_bist #(
    parameter int WIDTH  = BIST_WIDTH,
    parameter int SETTLE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [WIDTH-1:0]      dut_a,
    output logic [WIDTH-1:0]      dut_b,
    input  logic [WIDTH-1:0]      dut_sum,
    input  logic                  dut_carry,
    input  logic                  dut_overflow,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*WIDTH:0]      err_count,
    output logic [WIDTH-1:0]      fail_a,
    output logic [WIDTH-1:0]      fail_b,
    output logic [WIDTH+1:0]      fail_got
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [SET_W-1:0]  settle_cnt;

    logic [WIDTH-1:0]  exp_sum;
    logic              exp_carry;
    logic              exp_overflow;
    logic [WIDTH+1:0]  got;
    logic              mismatch;

    assign dut_a = idx[IDX_W-1:WIDTH];
    assign dut_b = idx[WIDTH-1:0];

    adder_bist_ref #(.WIDTH(WIDTH)) u_ref (
        .a        (dut_a),
        .b        (dut_b),
        .sum      (exp_sum),
        .carry    (exp_carry),
        .overflow (exp_overflow)
    );

    assign got      = {dut_carry, dut_overflow, dut_sum};
    assign mismatch = got != {exp_carry, exp_overflow, exp_sum};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_got   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= APPLY;
                        idx        <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_got   <= '0;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SET_W'(SETTLE - 1)) begin
                        state      <= CHECK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        // A zero count means no earlier failure in this run.
                        if (err_count == '0) begin
                            fail_a   <= dut_a;
                            fail_b   <= dut_b;
                            fail_got <= got;
                        end
                    end
                    if (idx == {IDX_W{1'b1}}) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == CNT_W'(0)) && !mismatch;
                    end else begin
                        state <= APPLY;
                        idx   <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
